// File: rtl/cdtv_subcode_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cdtv_subcode_pkg
//  Purpose   : Shared constants, register map, FSM state type and CRC-16
//              step function for the CDTV subcode Q-channel buffer.
//  Revision  : 1.0  initial release
// ============================================================================
package cdtv_subcode_pkg;

  // Frame geometry: 2 sync bytes followed by 96 payload bytes per SCOR.
  localparam int SUB_FRAME_LEN  = 98;
  localparam int SUB_SYNC_BYTES = 2;
  localparam int Q_BITS         = 96;
  localparam int Q_DATA_BITS    = 80;
  localparam int Q_DATA_BYTES   = 10;

  // CCITT polynomial x^16 + x^12 + x^5 + 1.
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // Host register map.
  localparam logic [3:0] ADDR_STATUS  = 4'd10;
  localparam logic [3:0] ADDR_CRC_CNT = 4'd11;
  localparam logic [3:0] ADDR_FRM_CNT = 4'd12;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    FRAME     = 2'd1,
    CHECK     = 2'd2
  } subq_state_e;

  // One MSB-first shift of the CRC register with input bit din.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdtv_crc16_serial.sv
`default_nettype none
// ============================================================================
//  Module    : cdtv_crc16_serial
//  Purpose   : Bit-serial CRC-16 (x^16+x^12+x^5+1), preset 0x0000, MSB
//              first. clr has priority over en.
//  Revision  : 1.0  initial release
// ============================================================================
module cdtv_crc16_serial
  import cdtv_subcode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value: restart on clr, otherwise advance one bit when enabled.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/cdtv_subq_buffer.sv
`default_nettype none
// ============================================================================
//  Module    : cdtv_subq_buffer
//  Purpose   : Assembles 98-byte subcode frames, extracts the 96 Q bits,
//              checks the Q CRC-16 and keeps the last good 10-byte Q record
//              in a host-readable shadow with status flags and error counts.
//  Config    : SUBQ_IRQ_EN - when defined, INT_n is driven low while
//              Q_READY or FRAME_ERR is set; otherwise INT_n is tied high.
//  Revision  : 1.0  initial release
// ============================================================================
module cdtv_subq_buffer
  import cdtv_subcode_pkg::*;
#(
  parameter int ERRCNT_W    = 8,
  parameter int SYNC_STAGES = 2
)(
  input  logic       CLK7,
  input  logic       IFRST_n,
  input  logic       SCOR,
  input  logic       SUB_STB,
  input  logic [7:0] SUB,
  input  logic       RD_STB,
  input  logic [3:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       Q_READY,
  output logic       INT_n
);

  localparam logic [6:0] FIRST_Q_BYTE  = 7'(SUB_SYNC_BYTES);
  localparam logic [6:0] LAST_CRC_BYTE = 7'(SUB_SYNC_BYTES + Q_DATA_BITS - 1);
  localparam logic [6:0] LAST_BYTE     = 7'(SUB_FRAME_LEN - 1);
  localparam logic [ERRCNT_W-1:0] CNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  // Only the Q bit of each subcode byte is consumed.
  logic sub_unused;
  assign sub_unused = ^{SUB[7], SUB[5:0]};

  // ---------------------------------------------------------------- state
  logic [SYNC_STAGES-1:0] scor_sync_q, scor_sync_d;
  logic [SYNC_STAGES-1:0] stb_sync_q,  stb_sync_d;
  logic                   scor_prev_q, scor_prev_d;
  logic                   stb_prev_q,  stb_prev_d;

  subq_state_e            state_q, state_d;
  logic [6:0]             byte_cnt_q, byte_cnt_d;
  logic [Q_BITS-1:0]      q_shift_q, q_shift_d;
  logic [Q_DATA_BITS-1:0] shadow_q, shadow_d;

  logic                   q_ready_q, q_ready_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   crc_err_q, crc_err_d;
  logic [ERRCNT_W-1:0]    crc_err_cnt_q, crc_err_cnt_d;
  logic [ERRCNT_W-1:0]    frm_err_cnt_q, frm_err_cnt_d;
  logic [7:0]             rd_data_q, rd_data_d;

  logic                   scor_pulse, stb_pulse;
  logic                   crc_clr, crc_en;
  logic                   check_pass, check_fail, frame_err_set;
  logic                   status_rd;
  logic [15:0]            crc_val;

  // Synchroniser chains and edge detection for the two async strobes.
  always_comb begin
    scor_sync_d = {scor_sync_q[SYNC_STAGES-2:0], SCOR};
    stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0], SUB_STB};
    scor_prev_d = scor_sync_q[SYNC_STAGES-1];
    stb_prev_d  = stb_sync_q[SYNC_STAGES-1];
    scor_pulse  = scor_sync_q[SYNC_STAGES-1] & ~scor_prev_q;
    stb_pulse   = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;
  end

  // Frame assembly FSM: byte counting, Q-bit capture and CRC feed.
  // A SCOR pulse always restarts the frame; a byte strobe in the same
  // cycle becomes byte 0 of the new frame.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    q_shift_d     = q_shift_q;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    check_pass    = 1'b0;
    check_fail    = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (scor_pulse) begin
          state_d    = FRAME;
          crc_clr    = 1'b1;
          byte_cnt_d = stb_pulse ? 7'd1 : 7'd0;
        end
      end
      FRAME: begin
        if (scor_pulse) begin
          frame_err_set = 1'b1;
          crc_clr       = 1'b1;
          byte_cnt_d    = stb_pulse ? 7'd1 : 7'd0;
        end else if (stb_pulse) begin
          if (byte_cnt_q >= FIRST_Q_BYTE) begin
            q_shift_d = {q_shift_q[Q_BITS-2:0], SUB[6]};
            crc_en    = (byte_cnt_q <= LAST_CRC_BYTE);
          end
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (crc_val == ~q_shift_q[15:0]) begin
          check_pass = 1'b1;
        end else begin
          check_fail = 1'b1;
        end
        state_d = WAIT_SYNC;
        // Do not lose a SCOR that lands in the single CHECK cycle.
        if (scor_pulse) begin
          state_d    = FRAME;
          crc_clr    = 1'b1;
          byte_cnt_d = stb_pulse ? 7'd1 : 7'd0;
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
  end

  cdtv_crc16_serial u_crc (
    .clk   (CLK7),
    .rst_n (IFRST_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (SUB[6]),
    .crc   (crc_val)
  );

  // Status flags, shadow update and saturating error counters.
  // A status read clears the flags, but a same-cycle set wins.
  always_comb begin
    status_rd     = RD_STB && (RD_ADDR == ADDR_STATUS);
    q_ready_d     = status_rd ? 1'b0 : q_ready_q;
    overrun_d     = status_rd ? 1'b0 : overrun_q;
    frame_err_d   = status_rd ? 1'b0 : frame_err_q;
    crc_err_d     = status_rd ? 1'b0 : crc_err_q;
    shadow_d      = shadow_q;
    crc_err_cnt_d = crc_err_cnt_q;
    frm_err_cnt_d = frm_err_cnt_q;
    if (check_pass) begin
      shadow_d  = q_shift_q[Q_BITS-1:Q_BITS-Q_DATA_BITS];
      overrun_d = q_ready_q;
      q_ready_d = 1'b1;
    end
    if (check_fail) begin
      crc_err_d = 1'b1;
      if (crc_err_cnt_q != {ERRCNT_W{1'b1}}) begin
        crc_err_cnt_d = crc_err_cnt_q + CNT_ONE;
      end
    end
    if (frame_err_set) begin
      frame_err_d = 1'b1;
      if (frm_err_cnt_q != {ERRCNT_W{1'b1}}) begin
        frm_err_cnt_d = frm_err_cnt_q + CNT_ONE;
      end
    end
  end

  // Host read mux; the result is registered and held between strobes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (RD_STB) begin
      rd_data_d = 8'h00;
      for (int i = 0; i < Q_DATA_BYTES; i++) begin
        if (RD_ADDR == 4'(i)) begin
          rd_data_d = shadow_q[(Q_DATA_BITS-1) - 8*i -: 8];
        end
      end
      if (RD_ADDR == ADDR_STATUS) begin
        rd_data_d = {4'b0000, overrun_q, frame_err_q, crc_err_q, q_ready_q};
      end
      if (RD_ADDR == ADDR_CRC_CNT) begin
        rd_data_d = 8'(crc_err_cnt_q);
      end
      if (RD_ADDR == ADDR_FRM_CNT) begin
        rd_data_d = 8'(frm_err_cnt_q);
      end
    end
  end

  // All block state registers.
  always_ff @(posedge CLK7 or negedge IFRST_n) begin
    if (!IFRST_n) begin
      scor_sync_q   <= '0;
      stb_sync_q    <= '0;
      scor_prev_q   <= 1'b0;
      stb_prev_q    <= 1'b0;
      state_q       <= WAIT_SYNC;
      byte_cnt_q    <= 7'd0;
      q_shift_q     <= '0;
      shadow_q      <= '0;
      q_ready_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      crc_err_cnt_q <= '0;
      frm_err_cnt_q <= '0;
      rd_data_q     <= 8'h00;
    end else begin
      scor_sync_q   <= scor_sync_d;
      stb_sync_q    <= stb_sync_d;
      scor_prev_q   <= scor_prev_d;
      stb_prev_q    <= stb_prev_d;
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      q_shift_q     <= q_shift_d;
      shadow_q      <= shadow_d;
      q_ready_q     <= q_ready_d;
      overrun_q     <= overrun_d;
      frame_err_q   <= frame_err_d;
      crc_err_q     <= crc_err_d;
      crc_err_cnt_q <= crc_err_cnt_d;
      frm_err_cnt_q <= frm_err_cnt_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign RD_DATA = rd_data_q;
  assign Q_READY = q_ready_q;

`ifdef SUBQ_IRQ_EN
  logic int_n_q, int_n_d;

  // Interrupt request: asserted while a new record or framing error is pending.
  always_comb begin
    int_n_d = ~(q_ready_d | frame_err_d);
  end

  // Registered interrupt output.
  always_ff @(posedge CLK7 or negedge IFRST_n) begin
    if (!IFRST_n) begin
      int_n_q <= 1'b1;
    end else begin
      int_n_q <= int_n_d;
    end
  end

  assign INT_n = int_n_q;
`else
  assign INT_n = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdtv_subq_buffer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_cdtv_subq_buffer
//  Purpose   : Directed self-checking bench for cdtv_subq_buffer.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_cdtv_subq_buffer;

  logic       clk;
  logic       ifrst_n;
  logic       scor;
  logic       sub_stb;
  logic [7:0] sub;
  logic       rd_stb;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       q_ready;
  logic       int_n;

  int n_checks;
  int n_fail;

`ifdef SUBQ_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam logic [79:0] REC_A = 80'h01010001000000000002;
  localparam logic [79:0] REC_B = 80'hA55A0F0F1234567890C3;
  localparam logic [79:0] REC_C = 80'h0102030405060708090A;

  cdtv_subq_buffer #(.ERRCNT_W(8), .SYNC_STAGES(2)) dut (
    .CLK7    (clk),
    .IFRST_n (ifrst_n),
    .SCOR    (scor),
    .SUB_STB (sub_stb),
    .SUB     (sub),
    .RD_STB  (rd_stb),
    .RD_ADDR (rd_addr),
    .RD_DATA (rd_data),
    .Q_READY (q_ready),
    .INT_n   (int_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRC-16 (x^16+x^12+x^5+1, preset 0, MSB first) over 80 data bits.
  function automatic logic [15:0] crc_model(input logic [79:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 79; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); sub_stb = 1'b1;
    @(negedge clk); sub_stb = 1'b0; sub = b;
  endtask

  task automatic send_scor();
    @(negedge clk); scor = 1'b1;
    @(negedge clk); scor = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] d, input bit bad);
    logic [95:0] q;
    q = {d, ~crc_model(d)};
    if (bad) q[0] = ~q[0];
    send_scor();
    send_byte(8'hC0);
    send_byte(8'h40);
    for (int i = 95; i >= 0; i--) begin
      send_byte({i[0], q[i], 6'h15});
    end
    idle(4);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); rd_stb = 1'b1; rd_addr = a;
    @(negedge clk); rd_stb = 1'b0; d = rd_data;
  endtask

  task automatic apply_reset();
    @(negedge clk); ifrst_n = 1'b0;
    idle(3);
    ifrst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    apply_reset();
    n_checks++;
    if (q_ready !== 1'b0) begin n_fail++; $display("FAIL reset_q_ready: got %b expected 0", q_ready); end
    n_checks++;
    if (int_n !== 1'b1) begin n_fail++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
    for (int a = 0; a < 13; a++) begin
      rd(4'(a), d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL reset_addr%0d: got %h expected 00", a, d); end
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] d;
    // Stray bytes with no frame open must be ignored.
    send_byte(8'hFF); send_byte(8'h40); send_byte(8'h7F);
    idle(4);
    send_frame(REC_A, 1'b0);
    n_checks++;
    if (q_ready !== 1'b1) begin n_fail++; $display("FAIL good_q_ready: got %b expected 1", q_ready); end
    n_checks++;
    if (int_n !== ~IRQ) begin n_fail++; $display("FAIL good_int_n: got %b expected %b", int_n, ~IRQ); end
    for (int a = 0; a < 10; a++) begin
      rd(4'(a), d);
      n_checks++;
      if (d !== REC_A[79-8*a -: 8]) begin n_fail++; $display("FAIL good_addr%0d: got %h expected %h", a, d, REC_A[79-8*a -: 8]); end
    end
    for (int a = 13; a < 16; a++) begin
      rd(4'(a), d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL good_addr%0d: got %h expected 00", a, d); end
    end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL good_status: got %h expected 01", d); end
    idle(1);
    n_checks++;
    if (q_ready !== 1'b0) begin n_fail++; $display("FAIL good_q_ready_clr: got %b expected 0", q_ready); end
    n_checks++;
    if (int_n !== 1'b1) begin n_fail++; $display("FAIL good_int_n_clr: got %b expected 1", int_n); end
  endtask

  task automatic test_crc_error();
    logic [7:0] d;
    send_frame(REC_A, 1'b1);
    n_checks++;
    if (q_ready !== 1'b0) begin n_fail++; $display("FAIL crc_q_ready: got %b expected 0", q_ready); end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL crc_status: got %h expected 02", d); end
    rd(4'd11, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL crc_cnt: got %h expected 01", d); end
    rd(4'd0, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL crc_shadow0: got %h expected 01", d); end
    rd(4'd9, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL crc_shadow9: got %h expected 02", d); end
  endtask

  task automatic test_frame_error();
    logic [7:0] d;
    send_scor();
    for (int i = 0; i < 50; i++) send_byte(8'h40);
    send_frame(REC_B, 1'b0);
    n_checks++;
    if (int_n !== ~IRQ) begin n_fail++; $display("FAIL frm_int_n: got %b expected %b", int_n, ~IRQ); end
    rd(4'd12, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL frm_cnt: got %h expected 01", d); end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h05) begin n_fail++; $display("FAIL frm_status: got %h expected 05", d); end
    for (int a = 0; a < 10; a++) begin
      rd(4'(a), d);
      n_checks++;
      if (d !== REC_B[79-8*a -: 8]) begin n_fail++; $display("FAIL frm_addr%0d: got %h expected %h", a, d, REC_B[79-8*a -: 8]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    send_frame(REC_A, 1'b0);
    send_frame(REC_C, 1'b0);
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h09) begin n_fail++; $display("FAIL b2b_status: got %h expected 09", d); end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL b2b_status_again: got %h expected 00", d); end
    rd(4'd9, d);
    n_checks++;
    if (d !== 8'h0A) begin n_fail++; $display("FAIL b2b_addr9: got %h expected 0a", d); end
    rd(4'd12, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL b2b_frm_cnt: got %h expected 01", d); end
  endtask

  task automatic test_crc_saturation();
    logic [7:0] d;
    // One CRC error is already counted; 255 more push the count past 0xFF.
    for (int f = 0; f < 255; f++) send_frame(REC_B, 1'b1);
    rd(4'd11, d);
    n_checks++;
    if (d !== 8'hFF) begin n_fail++; $display("FAIL sat_crc_cnt: got %h expected ff", d); end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL sat_status: got %h expected 02", d); end
    rd(4'd0, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL sat_shadow0: got %h expected 01", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    send_scor();
    for (int i = 0; i < 30; i++) send_byte(8'h40);
    apply_reset();
    n_checks++;
    if (q_ready !== 1'b0) begin n_fail++; $display("FAIL mid_q_ready: got %b expected 0", q_ready); end
    for (int a = 0; a < 13; a++) begin
      rd(4'(a), d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL mid_addr%0d: got %h expected 00", a, d); end
    end
    send_frame(REC_C, 1'b0);
    n_checks++;
    if (q_ready !== 1'b1) begin n_fail++; $display("FAIL mid_next_q_ready: got %b expected 1", q_ready); end
    rd(4'd0, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL mid_next_addr0: got %h expected 01", d); end
    rd(4'd5, d);
    n_checks++;
    if (d !== 8'h06) begin n_fail++; $display("FAIL mid_next_addr5: got %h expected 06", d); end
    rd(4'd10, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL mid_next_status: got %h expected 01", d); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ifrst_n  = 1'b0;
    scor     = 1'b0;
    sub_stb  = 1'b0;
    sub      = 8'h00;
    rd_stb   = 1'b0;
    rd_addr  = 4'd0;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_frame_error();
    test_back_to_back();
    test_crc_saturation();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
